// File: rtl/alu_wb_stage.sv
// alu_wb_stage: buffers ALU results in a 2-entry FIFO and retires each one as
// register-file write beats. A narrow entry is one beat, a wide entry is two
// beats (low half to dest, high half to dest+1).
// Optional build macro: WB_OVF_FLAG_EN enables the narrow-result overflow flag.
//
// state  | meaning
// IDLE   | nothing presented, waiting for a buffered entry
// LO     | presenting low half of the head entry at dest
// HI     | presenting high half of a wide head entry at dest+1
module alu_wb_stage #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   alu_result,
  input  logic              za,
  input  logic              zb,
  input  logic              eq,
  input  logic              gt,
  input  logic              lt,
  input  logic [AW-1:0]     dest,
  input  logic              wide,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [AW-1:0]     wb_addr,
  output logic [DW-1:0]     wb_data,
  output logic [4:0]        flags_q,
  output logic              ovf
);

  localparam int EW = 2*DW + 5 + AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;

  logic [EW-1:0]   mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            push;
  logic            pop;
  logic            beat;
  logic            more;

  logic [2*DW-1:0] head_result;
  logic [4:0]      head_flags;
  logic [AW-1:0]   head_dest;
  logic            head_wide;

  assign {head_result, head_flags, head_dest, head_wide} = mem[rd_ptr];

  // The reset term keeps the stage from advertising space while it is being cleared.
  assign in_ready = !rst && (count != 2'd2);
  assign push     = in_valid && in_ready;
  assign beat     = wb_valid && wb_ready;
  assign pop      = beat && ((state == S_LO && !head_wide) || state == S_HI);
  // Another entry will be at the head after this pop (already buffered or arriving now).
  assign more     = (count > 2'd1) || push;

  // FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {alu_result, lt, gt, eq, zb, za, dest, wide};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Beat sequencing; an entry pushed into an idle stage is presented on the next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (count != 2'd0 || push) state_nxt = S_LO;
      S_LO: begin
        if (beat) begin
          if (head_wide) state_nxt = S_HI;
          else           state_nxt = more ? S_LO : S_IDLE;
        end
      end
      S_HI: if (beat) state_nxt = more ? S_LO : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Write port is driven straight from the FIFO head, so it cannot change while stalled.
  always_comb begin
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    case (state)
      S_LO: begin
        wb_valid = 1'b1;
        wb_addr  = head_dest;
        wb_data  = head_result[DW-1:0];
      end
      S_HI: begin
        wb_valid = 1'b1;
        wb_addr  = head_dest + AW'(1);
        wb_data  = head_result[2*DW-1:DW];
      end
      default: ;
    endcase
  end

  // Retired flags follow the entry that was just popped.
  always_ff @(posedge clk) begin
    if (rst)      flags_q <= 5'd0;
    else if (pop) flags_q <= head_flags;
  end

`ifdef WB_OVF_FLAG_EN
  logic ovf_q;

  // A narrow write drops the high half; flag it when that half was non-zero.
  always_ff @(posedge clk) begin
    if (rst)      ovf_q <= 1'b0;
    else if (pop) ovf_q <= !head_wide && (|head_result[2*DW-1:DW]);
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
